// File: rtl/sprite_pkg.sv
// Shared types and constants for the animated sprite source.
package sprite_pkg;

  localparam int unsigned COORD_W       = 11;
  localparam int unsigned TICK_W        = 8;
  localparam int unsigned KEY_COLOR_DEF = 0;

  typedef enum logic [1:0] {
    SCALE_X1 = 2'd0,
    SCALE_X2 = 2'd1,
    SCALE_X4 = 2'd2
  } scale_e;

  // Left-shift amount for a scale code; the reserved code behaves as x1.
  function automatic logic [1:0] scale_shift(input logic [1:0] code);
    logic [1:0] s;
    s = 2'd0;
    case (code)
      SCALE_X2: s = 2'd1;
      SCALE_X4: s = 2'd2;
      default:  s = 2'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sprite_frame_ram.sv
// Sprite frame store: one write port, one registered read port, read-first.
module sprite_frame_ram #(
  parameter int unsigned ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_addr_w,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic [ADDR_WIDTH-1:0] i_addr_r,
  output logic [DATA_WIDTH-1:0] o_dout
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Read samples the array before the same-edge write lands.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr_w] <= i_din;
    o_dout <= r_mem[i_addr_r];
  end

endmodule

// File: rtl/sprite_anim_src.sv
// Animated, scalable, mirrorable sprite source; colour and opaque-hit out
// two clocks after the scan coordinate is presented.
module sprite_anim_src
  import sprite_pkg::*;
#(
  parameter int unsigned CD        = 12,
  parameter int unsigned H_SIZE    = 32,
  parameter int unsigned V_SIZE    = 64,
  parameter int unsigned NFRAME    = 4,
  parameter int unsigned FRAME_DIV = 8,
  parameter logic [CD-1:0] KEY_COLOR = CD'(KEY_COLOR_DEF),
  localparam int unsigned NW   = $clog2(NFRAME),
  localparam int unsigned FW   = (NW > 0) ? NW : 1,
  localparam int unsigned HW   = $clog2(H_SIZE),
  localparam int unsigned VW   = $clog2(V_SIZE),
  localparam int unsigned ADDR = NW + VW + HW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [1:0]         scale,
  input  logic               hflip,
  input  logic               anim_en,
  input  logic [FW-1:0]      frame_sel,
  input  logic               frame_tick,
  input  logic               we,
  input  logic [ADDR-1:0]    addr_w,
  input  logic [CD-1:0]      pixel_in,
  output logic [CD-1:0]      sprite_rgb,
  output logic               sprite_hit
);

  localparam int unsigned RW = COORD_W + 1;

  logic [1:0]    w_s;
  logic [RW-1:0] w_xr;
  logic [RW-1:0] w_yr;
  logic [RW-1:0] w_h_lim;
  logic [RW-1:0] w_v_lim;
  logic          w_in_region;
  logic [HW-1:0] w_col_raw;
  logic [HW-1:0] w_col;
  logic [VW-1:0] w_row;
  logic [ADDR-1:0] w_addr_r;
  logic [CD-1:0]   w_dout;

  logic [FW-1:0]     r_cur_frame;
  logic [TICK_W-1:0] r_tick_cnt;
  logic              r_hit_d1;

  // Relative coordinates: bit RW-1 set means the scan is left of / above the origin.
  always_comb begin
    w_s     = scale_shift(scale);
    w_xr    = {1'b0, x} - {1'b0, x0};
    w_yr    = {1'b0, y} - {1'b0, y0};
    w_h_lim = RW'(H_SIZE) << w_s;
    w_v_lim = RW'(V_SIZE) << w_s;
    w_in_region = !w_xr[RW-1] && !w_yr[RW-1] && (w_xr < w_h_lim) && (w_yr < w_v_lim);
    w_col_raw   = HW'(w_xr >> w_s);
    w_row       = VW'(w_yr >> w_s);
    // H_SIZE is a power of two, so H_SIZE-1-col is the bitwise complement.
    w_col       = hflip ? ~w_col_raw : w_col_raw;
  end

  generate
    if (NW == 0) begin : g_one_frame
      assign w_addr_r = {w_row, w_col};
    end else begin : g_multi_frame
      assign w_addr_r = {r_cur_frame[NW-1:0], w_row, w_col};
    end
  endgenerate

  // Frame selection updates only on frame_tick so a displayed frame never tears.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cur_frame <= '0;
      r_tick_cnt  <= '0;
    end else if (frame_tick) begin
      if (!anim_en) begin
        r_cur_frame <= (NFRAME > 1) ? frame_sel : FW'(0);
        r_tick_cnt  <= '0;
      end else if (r_tick_cnt == TICK_W'(FRAME_DIV - 1)) begin
        r_tick_cnt  <= '0;
        r_cur_frame <= (NFRAME > 1) ? FW'(r_cur_frame + FW'(1)) : FW'(0);
      end else begin
        r_tick_cnt  <= r_tick_cnt + TICK_W'(1);
      end
    end
  end

  sprite_frame_ram #(
    .ADDR_WIDTH (ADDR),
    .DATA_WIDTH (CD)
  ) u_ram (
    .clk      (clk),
    .i_we     (we),
    .i_addr_w (addr_w),
    .i_din    (pixel_in),
    .i_addr_r (w_addr_r),
    .o_dout   (w_dout)
  );

  // Two-stage output pipeline aligned with the RAM read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_d1   <= 1'b0;
      sprite_rgb <= KEY_COLOR;
      sprite_hit <= 1'b0;
    end else begin
      r_hit_d1   <= w_in_region;
      sprite_rgb <= r_hit_d1 ? w_dout : KEY_COLOR;
      sprite_hit <= r_hit_d1 && (w_dout != KEY_COLOR);
    end
  end

endmodule

// File: tb/tb_sprite_anim_src.sv
// Directed self-checking bench for sprite_anim_src (FRAME_DIV overridden to 2).
module tb_sprite_anim_src;

  localparam int unsigned CD   = 12;
  localparam int unsigned ADDR = 13;
  localparam int unsigned FW   = 2;
  localparam logic [CD-1:0] KEY = 12'h000;

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   x, y, x0, y0;
  logic [1:0]    scale;
  logic          hflip, anim_en, frame_tick, we;
  logic [FW-1:0] frame_sel;
  logic [ADDR-1:0] addr_w;
  logic [CD-1:0] pixel_in;
  logic [CD-1:0] sprite_rgb;
  logic          sprite_hit;

  int n_checks = 0;
  int n_fail   = 0;

  sprite_anim_src #(.FRAME_DIV(2)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .x0(x0), .y0(y0),
    .scale(scale), .hflip(hflip), .anim_en(anim_en), .frame_sel(frame_sel),
    .frame_tick(frame_tick), .we(we), .addr_w(addr_w), .pixel_in(pixel_in),
    .sprite_rgb(sprite_rgb), .sprite_hit(sprite_hit)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR-1:0] a, input logic [CD-1:0] d);
    we = 1'b1; addr_w = a; pixel_in = d;
    step();
    we = 1'b0;
  endtask

  // Present one coordinate and wait out the two-clock latency.
  task automatic probe(input int px, input int py);
    x = 11'(px); y = 11'(py);
    step();
    step();
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    n_checks++;
    if (sprite_rgb !== KEY || sprite_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: rgb=%h hit=%b, expected rgb=%h hit=0", sprite_rgb, sprite_hit, KEY);
    end
    reset = 1'b0;
    step();
    n_checks++;
    if (sprite_rgb !== KEY || sprite_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: rgb=%h hit=%b, expected rgb=%h hit=0", sprite_rgb, sprite_hit, KEY);
    end
  endtask

  task automatic fill_frame0();
    for (int r = 0; r < 64; r++)
      for (int c = 0; c < 32; c++)
        wr({2'd0, 6'(r), 5'(c)}, 12'((r << 5) | c));
  endtask

  task automatic test_scale1x();
    logic [CD-1:0] exp_rgb [3];
    logic          exp_hit [3];
    int            xs [3];
    exp_rgb[0] = 12'h065; exp_hit[0] = 1'b1; xs[0] = 105;
    exp_rgb[1] = 12'h066; exp_hit[1] = 1'b1; xs[1] = 106;
    exp_rgb[2] = KEY;     exp_hit[2] = 1'b0; xs[2] = 132;
    scale = 2'd0; hflip = 1'b0;
    // Back-to-back: one new coordinate per clock, results two clocks later.
    y = 11'd103;
    x = 11'(xs[0]); step();
    for (int i = 0; i < 3; i++) begin
      if (i < 2) x = 11'(xs[i+1]);
      step();
      n_checks++;
      if (sprite_rgb !== exp_rgb[i] || sprite_hit !== exp_hit[i]) begin
        n_fail++;
        $display("FAIL x1_pixel%0d: rgb=%h hit=%b, expected rgb=%h hit=%b",
                 i, sprite_rgb, sprite_hit, exp_rgb[i], exp_hit[i]);
      end
    end
  endtask

  task automatic test_scale_up();
    int px [7] = '{110, 111, 163, 164, 120, 105, 165};
    int py [7] = '{106, 107, 227, 100, 112, 103, 100};
    logic [1:0] sc [7] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [CD-1:0] er [7] = '{12'h065, 12'h065, 12'h7FF, KEY, 12'h065, 12'h065, KEY};
    logic eh [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      scale = sc[i];
      probe(px[i], py[i]);
      n_checks++;
      if (sprite_rgb !== er[i] || sprite_hit !== eh[i]) begin
        n_fail++;
        $display("FAIL scale_case%0d: rgb=%h hit=%b, expected rgb=%h hit=%b",
                 i, sprite_rgb, sprite_hit, er[i], eh[i]);
      end
    end
    scale = 2'd0;
  endtask

  task automatic test_hflip();
    hflip = 1'b1;
    probe(100, 100);
    n_checks++;
    if (sprite_rgb !== 12'h01F || sprite_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL hflip_left: rgb=%h hit=%b, expected rgb=01f hit=1", sprite_rgb, sprite_hit);
    end
    probe(131, 100);
    n_checks++;
    if (sprite_rgb !== 12'h000 || sprite_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL hflip_right: rgb=%h hit=%b, expected rgb=000 hit=0", sprite_rgb, sprite_hit);
    end
    probe(105, 103);
    n_checks++;
    if (sprite_rgb !== 12'h07A || sprite_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL hflip_mid: rgb=%h hit=%b, expected rgb=07a hit=1", sprite_rgb, sprite_hit);
    end
    hflip = 1'b0;
  endtask

  task automatic test_offscreen();
    x0 = 11'd2040; y0 = 11'd0;
    probe(2045, 3);
    n_checks++;
    if (sprite_rgb !== 12'h065 || sprite_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL offscreen_in: rgb=%h hit=%b, expected rgb=065 hit=1", sprite_rgb, sprite_hit);
    end
    probe(5, 3);
    n_checks++;
    if (sprite_rgb !== KEY || sprite_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL offscreen_wrap: rgb=%h hit=%b, expected rgb=%h hit=0", sprite_rgb, sprite_hit, KEY);
    end
    probe(2039, 3);
    n_checks++;
    if (sprite_rgb !== KEY || sprite_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL offscreen_neg: rgb=%h hit=%b, expected rgb=%h hit=0", sprite_rgb, sprite_hit, KEY);
    end
    x0 = 11'd100; y0 = 11'd100;
  endtask

  task automatic test_anim();
    int seq [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
    reset = 1'b1; step(); reset = 1'b0;
    for (int f = 0; f < 4; f++) wr({2'(f), 6'd0, 5'd0}, 12'(f + 1));
    anim_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulse_tick();
      probe(100, 100);
      n_checks++;
      if (sprite_rgb !== 12'(seq[i] + 1) || sprite_hit !== 1'b1) begin
        n_fail++;
        $display("FAIL anim_tick%0d: rgb=%h hit=%b, expected rgb=%h hit=1",
                 i + 1, sprite_rgb, sprite_hit, 12'(seq[i] + 1));
      end
    end
  endtask

  task automatic test_static_and_reset();
    anim_en = 1'b0; frame_sel = 2'd2;
    pulse_tick();
    probe(100, 100);
    n_checks++;
    if (sprite_rgb !== 12'h003) begin
      n_fail++;
      $display("FAIL static_sel2: rgb=%h, expected rgb=003", sprite_rgb);
    end
    frame_sel = 2'd1;
    probe(100, 100);
    n_checks++;
    if (sprite_rgb !== 12'h003) begin
      n_fail++;
      $display("FAIL static_no_tear: rgb=%h, expected rgb=003", sprite_rgb);
    end
    pulse_tick();
    probe(100, 100);
    n_checks++;
    if (sprite_rgb !== 12'h002) begin
      n_fail++;
      $display("FAIL static_sel1: rgb=%h, expected rgb=002", sprite_rgb);
    end
    x = 11'd100; y = 11'd100;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++;
    if (sprite_rgb !== KEY || sprite_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_reset: rgb=%h hit=%b, expected rgb=%h hit=0", sprite_rgb, sprite_hit, KEY);
    end
    probe(100, 100);
    n_checks++;
    if (sprite_rgb !== 12'h001 || sprite_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_frame0: rgb=%h hit=%b, expected rgb=001 hit=1", sprite_rgb, sprite_hit);
    end
  endtask

  task automatic test_read_first();
    x = 11'd100; y = 11'd100;
    we = 1'b1; addr_w = '0; pixel_in = 12'hABC;
    step();
    we = 1'b0;
    step();
    n_checks++;
    if (sprite_rgb !== 12'h001) begin
      n_fail++;
      $display("FAIL read_first_old: rgb=%h, expected rgb=001", sprite_rgb);
    end
    probe(100, 100);
    n_checks++;
    if (sprite_rgb !== 12'hABC || sprite_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL read_first_new: rgb=%h hit=%b, expected rgb=abc hit=1", sprite_rgb, sprite_hit);
    end
    wr(13'd1, KEY);
    probe(101, 100);
    n_checks++;
    if (sprite_rgb !== KEY || sprite_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL key_in_region: rgb=%h hit=%b, expected rgb=%h hit=0", sprite_rgb, sprite_hit, KEY);
    end
  endtask

  initial begin
    reset = 1'b1; x = '0; y = '0; x0 = 11'd100; y0 = 11'd100;
    scale = 2'd0; hflip = 1'b0; anim_en = 1'b0; frame_sel = '0;
    frame_tick = 1'b0; we = 1'b0; addr_w = '0; pixel_in = '0;
    test_reset();
    fill_frame0();
    test_scale1x();
    test_scale_up();
    test_hflip();
    test_offscreen();
    test_anim();
    test_static_and_reset();
    test_read_first();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
